master_circuit: RTL and testbench

//  Initiator for the slave 4x4 register-array/comparator interface (SW/SEL/LD -> LT).

---
 rtl/master_circuit_pkg.sv | 46 ++++
 rtl/master_circuit_reg_nb.sv | 29 ++
 rtl/master_circuit.sv | 199 +++++++++++++++++++
 tb/tb_master_circuit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/master_circuit_pkg.sv
// Shared definitions for the master/slave compare interface: FSM state
// encoding, LT bit positions and codes, SEL field layout.
package master_circuit_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_STROBE     = 3'd2,
    S_CMP_SET    = 3'd3,
    S_CMP_WAIT   = 3'd4,
    S_CMP_SAMPLE = 3'd5,
    S_DONE       = 3'd6
  } state_e;

  // LT bit indices as driven by the slave comparator.
  localparam int LT_LT = 2;  // column A < column B
  localparam int LT_EQ = 1;  // column A == column B
  localparam int LT_GT = 0;  // column A > column B

  // SEL field positions: {row, column A, column B}.
  localparam int SEL_ROW_LO = 4;
  localparam int SEL_A_LO   = 2;
  localparam int SEL_B_LO   = 0;

  // Number of rows / columns handled by the slave array.
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  // Build a SEL word from its three 2-bit fields.
  function automatic logic [5:0] pack_sel(input logic [1:0] row,
                                          input logic [1:0] col_a,
                                          input logic [1:0] col_b);
    logic [5:0] sel;
    sel = '0;
    sel[SEL_ROW_LO +: 2] = row;
    sel[SEL_A_LO   +: 2] = col_a;
    sel[SEL_B_LO   +: 2] = col_b;
    return sel;
  endfunction

  // One-hot row load strobe for the slave.
  function automatic logic [3:0] row_strobe(input logic [1:0] row);
    return 4'b0001 << row;
  endfunction

endpackage

// File: rtl/master_circuit_reg_nb.sv
// Generic n-bit register with synchronous clear and load enable; holds the
// per-row max-column result of the master.
module reg_nb #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [n-1:0] i_d,
  output logic [n-1:0] o_q
);

  logic [n-1:0] r_q;

  // Register: clear wins over load, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/master_circuit.sv
// Master for the slave 4x4 register-array/comparator: loads four row words
// into the slave (one LD pulse per row), then walks SEL compares over each
// row to find the column holding the largest nibble (ties keep the lowest).
module master_circuit
  import master_circuit_pkg::*;
#(
  parameter int N      = 4,
  parameter int SETTLE = 1
) (
  input  logic           CLK,
  input  logic           CLR,
  input  logic           START,
  input  logic [4*N-1:0] DIN,
  input  logic           DIN_VLD,
  output logic           DIN_RDY,
  input  logic [2:0]     LT,
  output logic [4*N-1:0] SW,
  output logic [5:0]     SEL,
  output logic [3:0]     LD,
  output logic           BUSY,
  output logic           DONE,
  output logic [7:0]     MAX_COL,
  output logic           ERR
);

  // Settle counter only has to reach SETTLE-1.
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

  state_e           r_state;
  state_e           w_next_state;

  logic [1:0]       r_row;
  logic [1:0]       r_col;
  logic [1:0]       r_best;
  logic [CNT_W-1:0] r_settle;
  logic [4*N-1:0]   r_sw;
  logic             r_err;

  logic             w_din_rdy;
  logic [3:0]       w_ld;
  logic [5:0]       w_sel;
  logic             w_busy;
  logic             w_done;

  logic             w_lt_better;
  logic             w_lt_legal;
  logic [1:0]       w_best_final;
  logic             w_last_col;
  logic             w_last_row;
  logic             w_run_start;
  logic             w_maxcol_en;
  logic [7:0]       w_maxcol_d;

  // Column B beats the current best only on a strict "A < B" code; ties and
  // "A > B" keep the lower column already held in best.
  assign w_lt_better  = LT[LT_LT] & ~LT[LT_EQ] & ~LT[LT_GT];
  assign w_lt_legal   = $onehot(LT);
  assign w_best_final = w_lt_better ? r_col : r_best;
  assign w_last_col   = (r_col == 2'd3);
  assign w_last_row   = (r_row == 2'd3);
  assign w_run_start  = (r_state == S_IDLE) && START;
  assign w_maxcol_en  = (r_state == S_CMP_SAMPLE) && w_last_col;

  // State register.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    w_next_state = r_state;
    w_din_rdy    = 1'b0;
    w_ld         = '0;
    w_sel        = '0;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (START) w_next_state = S_LOAD;
      end
      S_LOAD: begin
        w_din_rdy = 1'b1;
        if (DIN_VLD) w_next_state = S_STROBE;
      end
      S_STROBE: begin
        w_ld         = row_strobe(r_row);
        w_next_state = w_last_row ? S_CMP_SET : S_LOAD;
      end
      S_CMP_SET: begin
        w_sel        = pack_sel(r_row, r_best, r_col);
        w_next_state = S_CMP_WAIT;
      end
      S_CMP_WAIT: begin
        w_sel = pack_sel(r_row, r_best, r_col);
        if (r_settle == SETTLE_LAST) w_next_state = S_CMP_SAMPLE;
      end
      S_CMP_SAMPLE: begin
        w_sel        = pack_sel(r_row, r_best, r_col);
        w_next_state = (w_last_col && w_last_row) ? S_DONE : S_CMP_SET;
      end
      S_DONE: begin
        w_busy = 1'b0;
        w_done = 1'b1;
        // Wait for START to drop so a held button does not re-run.
        if (!START) w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Row/column/best/settle counters, SW capture and sticky error flag.
  always_ff @(posedge CLK or posedge CLR) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (CLR) begin
      r_row    <= '0;
      r_col    <= '0;
      r_best   <= '0;
      r_settle <= '0;
      r_sw     <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_row <= '0;
            r_err <= 1'b0;
          end
        end
        S_LOAD: begin
          if (DIN_VLD) r_sw <= DIN;
        end
        S_STROBE: begin
          if (w_last_row) begin
            r_row  <= '0;
            r_best <= '0;
            r_col  <= 2'd1;
          end else begin
            r_row <= r_row + 2'd1;
          end
        end
        S_CMP_SET: begin
          r_settle <= '0;
        end
        S_CMP_WAIT: begin
          r_settle <= r_settle + 1'b1;
        end
        S_CMP_SAMPLE: begin
          if (!w_lt_legal) r_err <= 1'b1;
          if (w_last_col) begin
            r_row  <= r_row + 2'd1;
            r_best <= '0;
            r_col  <= 2'd1;
          end else begin
            r_best <= w_best_final;
            r_col  <= r_col + 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Merge the finished row's best column into the result word.
  always_comb begin
    w_maxcol_d = MAX_COL;
    w_maxcol_d[2*r_row +: 2] = w_best_final;
  end

  reg_nb #(
    .n(8)
  ) u_maxcol_reg (
    .clk  (CLK),
    .rst  (CLR),
    .i_clr(w_run_start),
    .i_en (w_maxcol_en),
    .i_d  (w_maxcol_d),
    .o_q  (MAX_COL)
  );

  assign DIN_RDY = w_din_rdy;
  assign LD      = w_ld;
  assign SEL     = w_sel;
  assign BUSY    = w_busy;
  assign DONE    = w_done;
  assign SW      = r_sw;
  assign ERR     = r_err;

endmodule

// File: tb/tb_master_circuit.sv
// Bench for master_circuit: two instances (SETTLE=1 and SETTLE=3) share the
// board-side stimulus, each talking to its own behavioural slave model.
module tb_master_circuit;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [15:0] din;
  logic        din_vld;
  logic        force_bad;

  logic        rdy_a, busy_a, done_a, err_a;
  logic [15:0] sw_a;
  logic [5:0]  sel_a;
  logic [3:0]  ld_a;
  logic [7:0]  max_a;
  logic [2:0]  lt_a;

  logic        rdy_b, busy_b, done_b, err_b;
  logic [15:0] sw_b;
  logic [5:0]  sel_b;
  logic [3:0]  ld_b;
  logic [7:0]  max_b;
  logic [2:0]  lt_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  master_circuit #(.N(4), .SETTLE(1)) u_dut_a (
    .CLK(clk), .CLR(clr), .START(start), .DIN(din), .DIN_VLD(din_vld),
    .DIN_RDY(rdy_a), .LT(lt_a), .SW(sw_a), .SEL(sel_a), .LD(ld_a),
    .BUSY(busy_a), .DONE(done_a), .MAX_COL(max_a), .ERR(err_a)
  );

  master_circuit #(.N(4), .SETTLE(3)) u_dut_b (
    .CLK(clk), .CLR(clr), .START(start), .DIN(din), .DIN_VLD(din_vld),
    .DIN_RDY(rdy_b), .LT(lt_b), .SW(sw_b), .SEL(sel_b), .LD(ld_b),
    .BUSY(busy_b), .DONE(done_b), .MAX_COL(max_b), .ERR(err_b)
  );

  // Behavioural slaves: a row register per LD bit, comparator on SEL.
  logic [15:0] mem_a [4];
  logic [15:0] mem_b [4];

  always @(posedge clk) begin
    for (int r = 0; r < 4; r++) begin
      if (ld_a[r]) mem_a[r] <= sw_a;
      if (ld_b[r]) mem_b[r] <= sw_b;
    end
  end

  function automatic logic [2:0] slave_lt(input logic [15:0] row, input logic [5:0] sel);
    logic [3:0] a;
    logic [3:0] b;
    a = row[4*sel[3:2] +: 4];
    b = row[4*sel[1:0] +: 4];
    if (a < b)  return 3'b100;
    if (a == b) return 3'b010;
    return 3'b001;
  endfunction

  assign lt_a = force_bad ? 3'b000 : slave_lt(mem_a[sel_a[5:4]], sel_a);
  assign lt_b = slave_lt(mem_b[sel_b[5:4]], sel_b);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [63:0] rows;      // row r at [16r+15:16r], nibble 0 least significant
    int          gap;       // idle cycles on DIN_VLD after each accepted word
    int          force_at;  // first of 3 cycles with LT forced to 000 on A, -1 none
    logic [7:0]  exp_max;
    logic        exp_err;
    int          exp_lat_a; // first accept to DONE, SETTLE=1
    int          exp_lat_b; // first accept to DONE, SETTLE=3
  } vec_t;

  // One full run on both instances; clr_at >= 0 aborts with CLR at that cycle.
  task automatic run_case(input vec_t v, input int clr_at);
    int t, first, k, gapcnt, done_a_t, done_b_t, ld_n;
    logic [3:0]  ld_log [8];
    logic [15:0] sw_log [8];
    logic        sel_ok;
    logic [7:0]  cap_max_a;
    logic        cap_err_a, cap_busy_a;
    logic [5:0]  cap_sel_a;

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({v.tag, "_start_clears"}, {max_a, err_a, rdy_a}, {8'h00, 1'b0, 1'b1});

    t = 0; first = -1; k = 0; gapcnt = 0; done_a_t = -1; done_b_t = -1;
    ld_n = 0; sel_ok = 1'b1;
    cap_max_a = '0; cap_err_a = 1'b0; cap_busy_a = 1'b0; cap_sel_a = '0;
    while (t < 250) begin
      din       = (k < 4) ? v.rows[16*k +: 16] : 16'h0000;
      din_vld   = (k < 4) && (gapcnt == 0);
      force_bad = (v.force_at >= 0) && (t >= v.force_at) && (t < v.force_at + 3);
      if (clr_at >= 0 && t == clr_at) begin
        check({v.tag, "_pre_clr_max"}, max_a, v.exp_max);
        clr = 1'b1;
        #1;
        check({v.tag, "_clr_sw_sel_ld"}, {sw_a, sel_a, ld_a}, '0);
        check({v.tag, "_clr_max_err"}, {max_a, err_a}, '0);
        check({v.tag, "_clr_flags"}, {rdy_a, busy_a, done_a}, '0);
        @(negedge clk);
        clr = 1'b0; force_bad = 1'b0; din_vld = 1'b0;
        return;
      end
      #1;
      if (rdy_a && din_vld) begin
        if (first < 0) first = t;
        k++;
        gapcnt = v.gap;
      end else if (gapcnt > 0) begin
        gapcnt--;
      end
      if (ld_a != 4'b0000) begin
        if (ld_n < 8) begin
          ld_log[ld_n] = ld_a;
          sw_log[ld_n] = sw_a;
        end
        ld_n++;
        if (sel_a != 6'd0) sel_ok = 1'b0;
      end
      if (done_a && done_a_t < 0) begin
        done_a_t = t; cap_max_a = max_a; cap_err_a = err_a;
        cap_busy_a = busy_a; cap_sel_a = sel_a;
      end
      if (done_b && done_b_t < 0) done_b_t = t;
      if (done_a_t >= 0 && done_b_t >= 0) break;
      @(negedge clk);
      t++;
    end
    force_bad = 1'b0;
    din_vld   = 1'b0;

    check({v.tag, "_done_seen"}, {(done_a_t >= 0), (done_b_t >= 0)}, 2'b11);
    check({v.tag, "_lat_a"}, done_a_t - first, v.exp_lat_a);
    check({v.tag, "_lat_b"}, done_b_t - first, v.exp_lat_b);
    check({v.tag, "_max_a"}, cap_max_a, v.exp_max);
    check({v.tag, "_err_a"}, cap_err_a, v.exp_err);
    check({v.tag, "_done_busy_sel"}, {cap_busy_a, cap_sel_a}, '0);
    check({v.tag, "_max_b"}, max_b, v.exp_max);
    check({v.tag, "_err_b"}, err_b, 1'b0);
    check({v.tag, "_ld_count"}, ld_n, 4);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("%s_ld%0d", v.tag, j), ld_log[j], 4'b0001 << j);
      check($sformatf("%s_sw%0d", v.tag, j), sw_log[j], v.rows[16*j +: 16]);
    end
    check({v.tag, "_sel_zero_in_load"}, sel_ok, 1'b1);
    // A has been back in IDLE since START dropped; result stays held there.
    check({v.tag, "_a_idle_hold"}, {done_a, busy_a, max_a}, {1'b0, 1'b0, v.exp_max});
    @(negedge clk);
    @(negedge clk);
    check({v.tag, "_b_idle"}, {done_b, busy_b}, 2'b00);
  endtask

  vec_t vecs [5];
  vec_t v_clr;

  initial begin
    vecs[0] = '{"basic",   64'h7777_0F0F_4321_1234, 0, -1, 8'h0C, 1'b0, 44, 68};
    vecs[1] = '{"gapped",  64'h00B0_9000_0A00_5555, 3, -1, 8'h78, 1'b0, 50, 74};
    vecs[2] = '{"bad_lt",  64'h2F2F_0C3A_8001_5555, 0,  8, 8'h2C, 1'b1, 44, 68};
    vecs[3] = '{"rerun",   64'h7777_0F0F_4321_1234, 0, -1, 8'h0C, 1'b0, 44, 68};
    vecs[4] = '{"gap1",    64'h0FF0_E00E_3210_0001, 1, -1, 8'h4C, 1'b0, 44, 68};
    v_clr   = '{"abort",   64'h7777_0F0F_1234_4321, 0, -1, 8'h03, 1'b0, 44, 68};

    clr = 1'b1; start = 1'b0; din = '0; din_vld = 1'b0; force_bad = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_sw_sel_ld", {sw_a, sel_a, ld_a}, '0);
    check("reset_max_err", {max_a, err_a}, '0);
    check("reset_flags", {rdy_a, busy_a, done_a}, '0);
    clr = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {rdy_a, busy_a, done_a, sel_a, ld_a}, '0);

    for (int i = 0; i < 5; i++) run_case(vecs[i], -1);

    // Abort mid-compare, then a clean full run.
    run_case(v_clr, 20);
    check("abort_idle", {busy_a, done_a, max_a}, '0);
    run_case(vecs[0], -1);

    // START held through DONE: must sit in DONE, not restart.
    din = 16'h0F00; din_vld = 1'b1; start = 1'b1;
    for (int i = 0; i < 200 && !done_a; i++) @(negedge clk);
    check("hold_done_seen", done_a, 1'b1);
    repeat (5) @(negedge clk);
    check("hold_stays_done", {done_a, busy_a, rdy_a, ld_a}, {1'b1, 1'b0, 1'b0, 4'b0000});
    check("hold_max", max_a, 8'hAA);
    start = 1'b0; din_vld = 1'b0;
    @(negedge clk);
    check("hold_release_idle", {done_a, busy_a}, 2'b00);
    repeat (60) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
